// File: rtl/ap_mult_pipe_if.sv
// Operand/result handshake bundle for ap_mult_pipe.
interface ap_mult_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_apx;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_res;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_a, in_b, in_apx, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_apx, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag
  );
endinterface

// File: rtl/ap_mult_pipe.sv
// Pipelined signed Baugh-Wooley multiplier with optional approximate (OR) compression
// of the lowest APX_COLS columns, elastic valid/ready stages and an approximate-beat counter.
module ap_mult_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned APX_COLS = 7,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ap_mult_pipe_if.slave    bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] apx_cnt
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  // stage 0: operand capture
  logic             r0_v;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;
  logic             r0_apx;
  logic [TAG_W-1:0] r0_tag;
  // stage 1: carry-save pair
  logic             r1_v;
  logic [PW-1:0]    r1_s;
  logic [PW-1:0]    r1_c;
  logic [TAG_W-1:0] r1_tag;
  // stage 2: output register
  logic             r2_v;
  logic [PW-1:0]    r2_res;
  logic [TAG_W-1:0] r2_tag;

  logic             r_cnt_v;
  logic [CNT_W-1:0] r_cnt;

  logic             w_ld0;
  logic             w_ld1;
  logic             w_ld2;
  logic             w_bit;
  logic [PW-1:0]    w_row;
  logic [PW-1:0]    w_or;
  logic [PW-1:0]    w_s;
  logic [PW-1:0]    w_c;
  logic [PW-1:0]    w_t;

  // Stall chain: a stage loads when empty or when its content moves on this cycle.
  always_comb begin
    w_ld2 = !r2_v || bus.out_ready;
    w_ld1 = !r1_v || w_ld2;
    w_ld0 = !r0_v || w_ld1;
  end

  assign bus.in_ready  = w_ld0;
  assign bus.out_valid = r2_v;
  assign bus.out_res   = r2_res;
  assign bus.out_tag   = r2_tag;
  assign apx_cnt       = r_cnt;

  // Partial products per row; approximate columns diverted into an OR row that
  // never carries, everything else folded into a carry-save pair row by row.
  always_comb begin
    w_s   = '0;
    w_c   = '0;
    w_t   = '0;
    w_or  = '0;
    w_row = '0;
    w_bit = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_row = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
        w_bit = r0_a[j] & r0_b[i];
        if ((i == WIDTH - 1) != (j == WIDTH - 1))
          w_bit = ~w_bit;
        if (r0_apx && (i + j < APX_COLS))
          w_or = w_or | (PW'(w_bit) << (i + j));
        else
          w_row = w_row | (PW'(w_bit) << (i + j));
      end
      w_t = w_s ^ w_c ^ w_row;
      w_c = ((w_s & w_c) | (w_s & w_row) | (w_c & w_row)) << 1;
      w_s = w_t;
    end
    w_t = w_s ^ w_c ^ BW_CONST;
    w_c = ((w_s & w_c) | (w_s & BW_CONST) | (w_c & BW_CONST)) << 1;
    w_s = w_t;
    w_t = w_s ^ w_c ^ w_or;
    w_c = ((w_s & w_c) | (w_s & w_or) | (w_c & w_or)) << 1;
    w_s = w_t;
  end

  // S0 operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_v   <= 1'b0;
      r0_a   <= '0;
      r0_b   <= '0;
      r0_apx <= 1'b0;
      r0_tag <= '0;
    end else if (w_ld0) begin
      r0_v <= bus.in_valid;
      if (bus.in_valid) begin
        r0_a   <= bus.in_a;
        r0_b   <= bus.in_b;
        r0_apx <= bus.in_apx;
        r0_tag <= bus.in_tag;
      end
    end
  end

  // S1 carry-save result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v   <= 1'b0;
      r1_s   <= '0;
      r1_c   <= '0;
      r1_tag <= '0;
    end else if (w_ld1) begin
      r1_v <= r0_v;
      if (r0_v) begin
        r1_s   <= w_s;
        r1_c   <= w_c;
        r1_tag <= r0_tag;
      end
    end
  end

  // S2 final carry-propagate add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v   <= 1'b0;
      r2_res <= '0;
      r2_tag <= '0;
    end else if (w_ld2) begin
      r2_v <= r1_v;
      if (r1_v) begin
        r2_res <= r1_s + r1_c;
        r2_tag <= r1_tag;
      end
    end
  end

  assign r_cnt_v = bus.in_valid && w_ld0 && bus.in_apx;

  // Saturating count of accepted approximate beats; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (cnt_clr)
      r_cnt <= '0;
    else if (r_cnt_v && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end
endmodule
